// File: rtl/filter_seq_pkg.sv
// Shared constants, FSM state encoding and the slot tag that travels
// alongside each sample through the external filter's latency.
package filter_seq_pkg;

  localparam int DATA_W    = 8;
  localparam int OUT_W     = 16;
  localparam int LINE_LEN  = 128;
  localparam int HALF_TAPS = 8;
  localparam int FILT_LAT  = 12;
  localparam int MAX_LINES = 256;

  localparam int LINE_W = $clog2(MAX_LINES);
  localparam int IDX_W  = $clog2(LINE_LEN);
  localparam int ADDR_W = LINE_W + IDX_W;

  // Slots fed per line: the line itself plus H zeros on each side
  localparam int N      = LINE_LEN + 2 * HALF_TAPS;
  localparam int SLOT_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  // keep marks a slot whose filter result is a centred, fully-formed sample
  typedef struct packed {
    logic              keep;
    logic [LINE_W-1:0] line;
    logic [IDX_W-1:0]  idx;
  } tag_t;

endpackage

// File: rtl/filter_line_sequencer_if.sv
// Bundle of the sequencer's control, projection-read, filter and
// filtered-write signals. master = sequencer, slave = its surroundings.
interface filter_line_sequencer_if;
  import filter_seq_pkg::*;

  logic              start;
  logic [LINE_W:0]   num_lines;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] in_addr;
  logic              in_re;
  logic [DATA_W-1:0] in_data;
  logic              filt_en;
  logic [DATA_W-1:0] filt_val_in;
  logic [OUT_W-1:0]  filt_val_out;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [OUT_W-1:0]  out_data;

  modport master (
    input  start, num_lines, in_data, filt_val_out,
    output busy, done, in_addr, in_re, filt_en, filt_val_in,
           out_we, out_addr, out_data
  );

  modport slave (
    output start, num_lines, in_data, filt_val_out,
    input  busy, done, in_addr, in_re, filt_en, filt_val_in,
           out_we, out_addr, out_data
  );

endinterface

// File: rtl/filter_tag_delay.sv
// Shift register that delays slot tags by the filter latency so each tag
// lines up with the filter output it describes.
module filter_tag_delay
  import filter_seq_pkg::*;
#(
  parameter int DEPTH = FILT_LAT + 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic pending
);

  tag_t [DEPTH-1:0] pipe_q, pipe_d;

  // Next pipeline contents: new tag enters stage 0, all others move up
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipeline registers; reset clears every stage so nothing stale is written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Keeps not yet at the output stage; once clear, the current output
  // stage holds the final write of the run
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | pipe_q[i].keep;
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/filter_line_sequencer.sv
// Streams zero-padded projection lines into the external FIR filter and
// writes back only the centred filter results, one per input sample.
module filter_line_sequencer
  import filter_seq_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  filter_line_sequencer_if.master io
);

  localparam logic [SLOT_W-1:0] FEED_LO   = SLOT_W'(HALF_TAPS);
  localparam logic [SLOT_W-1:0] FEED_HI   = SLOT_W'(HALF_TAPS + LINE_LEN);
  localparam logic [SLOT_W-1:0] KEEP_LO   = SLOT_W'(2 * HALF_TAPS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N - 1);

  seq_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W:0]   lines_q, lines_d;
  logic              feed_q, feed_d;

  logic issue, feed, keep, pending;
  tag_t tag_in, tag_out;

  // Classify the slot being issued this cycle and build its tag
  always_comb begin
    issue  = (state_q == RUN);
    feed   = issue && (slot_q >= FEED_LO) && (slot_q < FEED_HI);
    keep   = issue && (slot_q >= KEEP_LO);
    tag_in = '0;
    if (keep) begin
      tag_in.keep = 1'b1;
      tag_in.line = line_q;
      tag_in.idx  = IDX_W'(slot_q - KEEP_LO);
    end
  end

  // Sequencing: walk slots within a line, lines within a run, then drain
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    line_d  = line_q;
    lines_d = lines_q;
    feed_d  = feed;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          if (io.num_lines == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            lines_d = io.num_lines;
            slot_d  = '0;
            line_d  = '0;
          end
        end
      end
      RUN: begin
        if (slot_q == LAST_SLOT) begin
          slot_d = '0;
          if ({1'b0, line_q} == lines_q - 1'b1) begin
            state_d = DRAIN;
            line_d  = '0;
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!pending) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      line_q  <= '0;
      lines_q <= '0;
      feed_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      line_q  <= line_d;
      lines_q <= lines_d;
      feed_q  <= feed_d;
    end
  end

  filter_tag_delay #(
    .DEPTH (FILT_LAT + 1)
  ) u_tag_delay (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .pending (pending)
  );

  assign io.busy        = (state_q == RUN) || (state_q == DRAIN);
  assign io.done        = (state_q == DONE);
  assign io.filt_en     = io.busy;
  assign io.in_re       = feed;
  assign io.in_addr     = feed ? {line_q, IDX_W'(slot_q - FEED_LO)} : '0;
  assign io.filt_val_in = feed_q ? io.in_data : '0;
  assign io.out_we      = tag_out.keep;
  assign io.out_addr    = {tag_out.line, tag_out.idx};
  assign io.out_data    = io.filt_val_out;

endmodule

// File: tb/tb_filter_line_sequencer.sv
// Bench for filter_line_sequencer: projection buffer and a 17-tap FIR
// filter are modelled here; outputs are checked against direct arithmetic.
module tb_filter_line_sequencer;
  import filter_seq_pkg::*;

  localparam int L    = LINE_LEN;
  localparam int H    = HALF_TAPS;
  localparam int TAPS = 2 * H + 1;

  typedef struct {
    int                rel;
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  data;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  filter_line_sequencer_if io ();

  filter_line_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Projection buffer contents (lines 0..3) with one-cycle read latency
  logic [DATA_W-1:0] mem [0:3][0:L-1];
  always @(posedge clk) begin
    if (io.in_re) io.in_data <= mem[io.in_addr[IDX_W+1:IDX_W]][io.in_addr[IDX_W-1:0]];
    else          io.in_data <= DATA_W'($urandom);
  end

  // Ramp kernel h[i] = i+1; y[s] = sum h[i]*x[s-i]
  function automatic int h(int i);
    return i + 1;
  endfunction

  // Filter model: FIR over enabled samples, result FILT_LAT cycles later
  logic [DATA_W-1:0] xh [0:TAPS-1];
  logic [OUT_W-1:0]  yp [0:FILT_LAT-1];
  int facc;
  always @(posedge clk) begin
    if (io.filt_en) begin
      facc = h(0) * int'(io.filt_val_in);
      for (int i = 1; i < TAPS; i++) facc = facc + h(i) * int'(xh[i-1]);
      xh[0] <= io.filt_val_in;
      for (int i = 1; i < TAPS; i++) xh[i] <= xh[i-1];
      yp[0] <= OUT_W'(facc);
      for (int i = 1; i < FILT_LAT; i++) yp[i] <= yp[i-1];
    end
  end
  assign io.filt_val_out = yp[FILT_LAT-1];

  // Reference: centred output k of line j with zero padding beyond the line
  function automatic logic [OUT_W-1:0] exp_sample(int j, int k);
    int acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      int idx = k + H - i;
      if (idx >= 0 && idx < L) acc += h(i) * int'(mem[j][idx]);
    end
    return OUT_W'(acc);
  endfunction

  // Event logging relative to the accept cycle t0
  ev_t  wr_q[$];
  ev_t  rd_q[$];
  int   done_q[$];
  logic [DATA_W-1:0] fin_log [0:1023];
  logic              busy_log[0:1023];
  bit   log_en = 1'b0;
  int   t0 = 0;
  int   mrel;

  // Sample DUT outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (log_en) begin
      mrel = cyc - t0;
      if (mrel >= 0 && mrel < 1024) begin
        fin_log[mrel]  = io.filt_val_in;
        busy_log[mrel] = io.busy;
      end
      if (io.out_we) wr_q.push_back('{mrel, io.out_addr, io.out_data});
      if (io.in_re)  rd_q.push_back('{mrel, io.in_addr, '0});
      if (io.done)   done_q.push_back(mrel);
    end
  end

  task automatic clear_logs();
    log_en = 1'b0;
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    for (int i = 0; i < 1024; i++) begin
      fin_log[i]  = '0;
      busy_log[i] = 1'b0;
    end
  endtask

  task automatic launch(int m);
    clear_logs();
    @(negedge clk);
    t0           = cyc;
    io.start     = 1'b1;
    io.num_lines = (LINE_W+1)'(m);
    log_en       = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
  endtask

  task automatic wait_done(int budget, bit spam, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (io.done) begin
        timed_out = 1'b0;
        break;
      end
      if (spam) begin
        io.start     = 1'b1;
        io.num_lines = (LINE_W+1)'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    io.start = 1'b0;
    repeat (4) @(negedge clk);
    log_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [2*ADDR_W+DATA_W+5:0] obs;
    io.start     = 1'b0;
    io.num_lines = '0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    obs = {io.busy, io.done, io.in_re, io.in_addr, io.filt_en, io.filt_val_in, io.out_we, io.out_addr};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h want 0", obs);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    obs = {io.busy, io.done, io.in_re, io.in_addr, io.filt_en, io.filt_val_in, io.out_we, io.out_addr};
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL idle_outputs: got %h want 0", obs);
    end
    n_checks++;
    if (io.out_data !== io.filt_val_out) begin
      n_fail++;
      $display("[TB] FAIL out_data_follow: got %h want %h", io.out_data, io.filt_val_out);
    end
  endtask

  task automatic test_single_line();
    bit to;
    int exp_done = 2 + N + FILT_LAT;
    for (int k = 0; k < L; k++) mem[0][k] = DATA_W'(k);
    launch(1);
    wait_done(N + 60, 1'b0, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("[TB] FAIL single_timeout: got no done want done");
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != exp_done) begin
      n_fail++;
      $display("[TB] FAIL single_done: got %0d pulses first at %0d want 1 at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done);
    end
    n_checks++;
    if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1 || busy_log[exp_done-1] !== 1'b1 || busy_log[exp_done] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_busy: got %b%b%b%b want 0110", busy_log[0], busy_log[1],
               busy_log[exp_done-1], busy_log[exp_done]);
    end
    for (int s = 0; s < N; s++) begin
      logic [DATA_W-1:0] ev = (s < H || s >= H + L) ? '0 : mem[0][s-H];
      n_checks++;
      if (fin_log[2+s] !== ev) begin
        n_fail++;
        $display("[TB] FAIL single_fin slot %0d: got %0d want %0d", s, fin_log[2+s], ev);
      end
    end
    n_checks++;
    if (rd_q.size() != L) begin
      n_fail++;
      $display("[TB] FAIL single_reads: got %0d want %0d", rd_q.size(), L);
    end
    for (int q = 0; q < rd_q.size() && q < L; q++) begin
      n_checks++;
      if (rd_q[q].rel != 1 + H + q || rd_q[q].addr !== ADDR_W'(q)) begin
        n_fail++;
        $display("[TB] FAIL single_read %0d: got cyc %0d addr %0d want cyc %0d addr %0d",
                 q, rd_q[q].rel, rd_q[q].addr, 1 + H + q, q);
      end
    end
    n_checks++;
    if (wr_q.size() != L) begin
      n_fail++;
      $display("[TB] FAIL single_writes: got %0d want %0d", wr_q.size(), L);
    end
    for (int q = 0; q < wr_q.size() && q < L; q++) begin
      int er = 2 + q + 2 * H + FILT_LAT;
      logic [OUT_W-1:0] ed = exp_sample(0, q);
      n_checks++;
      if (wr_q[q].rel != er || wr_q[q].addr !== ADDR_W'(q) || wr_q[q].data !== ed) begin
        n_fail++;
        $display("[TB] FAIL single_write %0d: got cyc %0d addr %0d data %0d want cyc %0d addr %0d data %0d",
                 q, wr_q[q].rel, wr_q[q].addr, wr_q[q].data, er, q, ed);
      end
    end
  endtask

  task automatic test_impulse();
    bit to;
    for (int k = 0; k < L; k++) mem[0][k] = '0;
    mem[0][0]   = 8'd200;
    mem[0][L-1] = 8'd255;
    launch(1);
    wait_done(N + 60, 1'b0, to);
    n_checks++;
    if (to || wr_q.size() != L) begin
      n_fail++;
      $display("[TB] FAIL impulse_count: got %0d writes timeout %0b want %0d", wr_q.size(), to, L);
    end
    for (int q = 0; q < wr_q.size() && q < L; q++) begin
      logic [OUT_W-1:0] ed = exp_sample(0, q);
      n_checks++;
      if (wr_q[q].data !== ed || wr_q[q].addr !== ADDR_W'(q)) begin
        n_fail++;
        $display("[TB] FAIL impulse_write %0d: got addr %0d data %0d want addr %0d data %0d",
                 q, wr_q[q].addr, wr_q[q].data, q, ed);
      end
    end
    if (wr_q.size() == L) begin
      n_checks++;
      if (wr_q[0].data !== 16'd1800 || wr_q[H].data !== 16'd3400 || wr_q[L-1].data !== 16'd2295) begin
        n_fail++;
        $display("[TB] FAIL impulse_edges: got %0d %0d %0d want 1800 3400 2295",
                 wr_q[0].data, wr_q[H].data, wr_q[L-1].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int m = 3;
    for (int j = 0; j < m; j++)
      for (int k = 0; k < L; k++) mem[j][k] = DATA_W'($urandom);
    launch(m);
    wait_done(m * N + 60, 1'b0, to);
    n_checks++;
    if (to || done_q.size() != 1 || done_q[0] != 2 + m * N + FILT_LAT) begin
      n_fail++;
      $display("[TB] FAIL b2b_done: got %0d pulses timeout %0b want 1 at %0d",
               done_q.size(), to, 2 + m * N + FILT_LAT);
    end
    n_checks++;
    if (rd_q.size() != m * L || wr_q.size() != m * L) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d reads %0d writes want %0d", rd_q.size(), wr_q.size(), m * L);
    end
    for (int q = 0; q < rd_q.size() && q < m * L; q++) begin
      int j = q / L;
      int k = q % L;
      logic [ADDR_W-1:0] ea = {LINE_W'(j), IDX_W'(k)};
      n_checks++;
      if (rd_q[q].rel != 1 + j * N + H + k || rd_q[q].addr !== ea) begin
        n_fail++;
        $display("[TB] FAIL b2b_read %0d: got cyc %0d addr %h want cyc %0d addr %h",
                 q, rd_q[q].rel, rd_q[q].addr, 1 + j * N + H + k, ea);
      end
    end
    for (int q = 0; q < wr_q.size() && q < m * L; q++) begin
      int j = q / L;
      int k = q % L;
      int er = 2 + j * N + k + 2 * H + FILT_LAT;
      logic [ADDR_W-1:0] ea = {LINE_W'(j), IDX_W'(k)};
      logic [OUT_W-1:0]  ed = exp_sample(j, k);
      n_checks++;
      if (wr_q[q].rel != er || wr_q[q].addr !== ea || wr_q[q].data !== ed) begin
        n_fail++;
        $display("[TB] FAIL b2b_write %0d: got cyc %0d addr %h data %0d want cyc %0d addr %h data %0d",
                 q, wr_q[q].rel, wr_q[q].addr, wr_q[q].data, er, ea, ed);
      end
    end
  endtask

  task automatic test_start_spam();
    bit to;
    int m = 2;
    for (int j = 0; j < m; j++)
      for (int k = 0; k < L; k++) mem[j][k] = DATA_W'($urandom);
    launch(m);
    wait_done(m * N + 60, 1'b1, to);
    n_checks++;
    if (to || done_q.size() != 1 || done_q[0] != 2 + m * N + FILT_LAT || wr_q.size() != m * L) begin
      n_fail++;
      $display("[TB] FAIL spam_run: got %0d done %0d writes timeout %0b want 1 done at %0d and %0d writes",
               done_q.size(), wr_q.size(), to, 2 + m * N + FILT_LAT, m * L);
    end
    for (int q = 0; q < wr_q.size() && q < m * L; q++) begin
      int j = q / L;
      int k = q % L;
      logic [ADDR_W-1:0] ea = {LINE_W'(j), IDX_W'(k)};
      logic [OUT_W-1:0]  ed = exp_sample(j, k);
      n_checks++;
      if (wr_q[q].rel != 2 + j * N + k + 2 * H + FILT_LAT || wr_q[q].addr !== ea || wr_q[q].data !== ed) begin
        n_fail++;
        $display("[TB] FAIL spam_write %0d: got cyc %0d addr %h data %0d want addr %h data %0d",
                 q, wr_q[q].rel, wr_q[q].addr, wr_q[q].data, ea, ed);
      end
    end
    launch(0);
    wait_done(10, 1'b0, to);
    n_checks++;
    if (to || done_q.size() != 1 || done_q[0] != 1) begin
      n_fail++;
      $display("[TB] FAIL zero_done: got %0d pulses first at %0d want 1 at 1",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
    n_checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || busy_log[1] !== 1'b0 || busy_log[2] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_activity: got %0d writes %0d reads busy %b%b want none",
               wr_q.size(), rd_q.size(), busy_log[1], busy_log[2]);
    end
  endtask

  task automatic test_reset_midrun();
    bit to;
    int rst_rel;
    int late = 0;
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < L; k++) mem[j][k] = DATA_W'($urandom);
    launch(3);
    while (cyc - t0 < 1 + N + H + 40) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    rst_rel = cyc - t0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    log_en = 1'b0;
    foreach (wr_q[i]) if (wr_q[i].rel >= rst_rel) late++;
    n_checks++;
    if (late != 0 || done_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_quiet: got %0d late writes %0d done want 0 0", late, done_q.size());
    end
    n_checks++;
    if (io.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b want 0", io.busy);
    end
    launch(1);
    wait_done(N + 60, 1'b0, to);
    n_checks++;
    if (to || wr_q.size() != L || done_q.size() != 1 || done_q[0] != 2 + N + FILT_LAT) begin
      n_fail++;
      $display("[TB] FAIL restart_run: got %0d writes %0d done timeout %0b want %0d writes 1 done",
               wr_q.size(), done_q.size(), to, L);
    end
    for (int q = 0; q < wr_q.size() && q < L; q++) begin
      logic [OUT_W-1:0] ed = exp_sample(0, q);
      n_checks++;
      if (wr_q[q].rel != 2 + q + 2 * H + FILT_LAT || wr_q[q].addr !== ADDR_W'(q) || wr_q[q].data !== ed) begin
        n_fail++;
        $display("[TB] FAIL restart_write %0d: got cyc %0d addr %0d data %0d want addr %0d data %0d",
                 q, wr_q[q].rel, wr_q[q].addr, wr_q[q].data, q, ed);
      end
    end
  endtask

  // Filter history starts from arbitrary non-zero junk
  initial begin
    for (int i = 0; i < TAPS; i++) xh[i] = DATA_W'($urandom);
    for (int i = 0; i < FILT_LAT; i++) yp[i] = OUT_W'($urandom);
    io.in_data = '0;
  end

  // Scenario sequence
  initial begin
    test_reset();
    test_single_line();
    test_impulse();
    test_back_to_back();
    test_start_spam();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test want end before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
